// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick with last-grant register.
// Define RAM_ARB_FIXED_PRIO_EN to make port A always win contention.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic grant_i,
  output logic valid_o,
  output logic owner_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    valid_o = req_a_i | req_b_i;
`ifdef RAM_ARB_FIXED_PRIO_EN
    if (req_a_i) begin
      owner_o = PORT_A;
    end else begin
      owner_o = PORT_B;
    end
`else
    if (req_a_i && req_b_i) begin
      // Under contention the port that did not win last time goes next.
      owner_o = (last_grant_q == PORT_A) ? PORT_B : PORT_A;
    end else if (req_a_i) begin
      owner_o = PORT_A;
    end else begin
      owner_o = PORT_B;
    end
`endif
    last_grant_d = last_grant_q;
    if (grant_i && valid_o) begin
      last_grant_d = owner_o;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for a single-port synchronous RAM.
// Build option RAM_ARB_FIXED_PRIO_EN selects fixed A-over-B priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqA,
  input  logic              weA,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [DATA_W-1:0] wdataA,
  output logic              ackA,
  output logic [DATA_W-1:0] rdataA,
  input  logic              reqB,
  input  logic              weB,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] wdataB,
  output logic              ackB,
  output logic [DATA_W-1:0] rdataB,
  output logic              ram_writeOn,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_e              state_q;
  logic                owner_q;
  logic                ack_a_q;
  logic                ack_b_q;
  logic [DATA_W-1:0]   rdata_a_q;
  logic [DATA_W-1:0]   rdata_b_q;
  logic                wr_on_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                pick_valid;
  logic                pick_owner;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_a_i (reqA),
    .req_b_i (reqB),
    .grant_i (state_q == IDLE),
    .valid_o (pick_valid),
    .owner_o (pick_owner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= PORT_A;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      wr_on_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_owner;
            state_q <= ISSUE;
            if (pick_owner == PORT_A) begin
              wr_on_q <= weA;
              addr_q  <= addrA;
              wdata_q <= wdataA;
            end else begin
              wr_on_q <= weB;
              addr_q  <= addrB;
              wdata_q <= wdataB;
            end
          end
        end
        ISSUE: begin
          // The RAM acts on this edge; never let a write linger.
          wr_on_q <= 1'b0;
          state_q <= RESP;
        end
        RESP: begin
          if (owner_q == PORT_A) begin
            ack_a_q   <= 1'b1;
            rdata_a_q <= ram_data_out;
          end else begin
            ack_b_q   <= 1'b1;
            rdata_b_q <= ram_data_out;
          end
          state_q <= IDLE;
        end
        default: begin
          wr_on_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ackA        = ack_a_q;
  assign ackB        = ack_b_q;
  assign rdataA      = rdata_a_q;
  assign rdataB      = rdata_b_q;
  assign ram_writeOn = wr_on_q;
  assign ram_address = addr_q;
  assign ram_data_in = wdata_q;

endmodule
